// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// Round-robin sequencer placing commands from two requesters (core, debug/loader)
// onto a single-clock register-file RAM. The RAM has two registered read ports
// and one write port. At most one command goes to the RAM per cycle. Read data
// comes back one cycle later and is routed to the port that issued the read.
// The block also counts cycles in which both requesters want the RAM.
module regfile_arbiter #(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic          p0_wr,
    input  logic [AW-1:0] p0_addr_a,
    input  logic [AW-1:0] p0_addr_b,
    input  logic [AW-1:0] p0_addr_d,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata_a,
    output logic [DW-1:0] p0_rdata_b,

    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic          p1_wr,
    input  logic [AW-1:0] p1_addr_a,
    input  logic [AW-1:0] p1_addr_b,
    input  logic [AW-1:0] p1_addr_d,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata_a,
    output logic [DW-1:0] p1_rdata_b,

    output logic [AW-1:0] ram_addr_a,
    output logic [AW-1:0] ram_addr_b,
    output logic [AW-1:0] ram_addr_d,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q_a,
    input  logic [DW-1:0] ram_q_b,

    output logic [CW-1:0] conflict_cnt
);

    // Port that won the most recent issue; starts at 1 so port 0 wins first contention.
    logic          last_gnt;
    // One-hot owner of the read response arriving this cycle.
    logic [1:0]    rsel;
    logic [CW-1:0] cnt;
    logic          gnt0;
    logic          gnt1;
    logic          both_valid;

    assign both_valid = p0_valid && p1_valid;

    // Grant: a lone requester wins; on contention the port that did not win last time wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (both_valid) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = p0_valid;
                gnt1 = p1_valid;
            end
        end
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // RAM drive from the granted port; everything idles at zero when nobody issues.
    always_comb begin
        ram_addr_a  = '0;
        ram_addr_b  = '0;
        ram_addr_d  = '0;
        ram_data_in = '0;
        ram_we      = 1'b0;
        if (gnt0) begin
            ram_addr_a  = p0_addr_a;
            ram_addr_b  = p0_addr_b;
            ram_addr_d  = p0_addr_d;
            ram_data_in = p0_wdata;
            ram_we      = p0_wr;
        end else if (gnt1) begin
            ram_addr_a  = p1_addr_a;
            ram_addr_b  = p1_addr_b;
            ram_addr_d  = p1_addr_d;
            ram_data_in = p1_wdata;
            ram_we      = p1_wr;
        end
    end

    // Round-robin pointer follows every issue and holds while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end

    // Remember which port issued a read so its data, one cycle later, goes back to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsel <= 2'b00;
        end else begin
            rsel <= {gnt1 && !p1_wr, gnt0 && !p0_wr};
        end
    end

    // Contention counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (both_valid && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign conflict_cnt = cnt;

    // Responses are masked during reset so a read in flight at reset is dropped.
    assign p0_rvalid  = rsel[0] && !rst;
    assign p1_rvalid  = rsel[1] && !rst;
    assign p0_rdata_a = ram_q_a;
    assign p0_rdata_b = ram_q_b;
    assign p1_rdata_a = ram_q_a;
    assign p1_rdata_b = ram_q_b;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: behavioural RAM plus a reference model of the
// arbitration and response rules, directed scenarios followed by random traffic.
module tb_regfile_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          p0_valid, p0_ready, p0_wr, p0_rvalid;
    logic [AW-1:0] p0_addr_a, p0_addr_b, p0_addr_d;
    logic [DW-1:0] p0_wdata, p0_rdata_a, p0_rdata_b;
    logic          p1_valid, p1_ready, p1_wr, p1_rvalid;
    logic [AW-1:0] p1_addr_a, p1_addr_b, p1_addr_d;
    logic [DW-1:0] p1_wdata, p1_rdata_a, p1_rdata_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b, ram_addr_d;
    logic [DW-1:0] ram_data_in, ram_q_a, ram_q_b;
    logic          ram_we;
    logic [CW-1:0] conflict_cnt;

    regfile_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_wr(p0_wr),
        .p0_addr_a(p0_addr_a), .p0_addr_b(p0_addr_b), .p0_addr_d(p0_addr_d),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid),
        .p0_rdata_a(p0_rdata_a), .p0_rdata_b(p0_rdata_b),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_wr(p1_wr),
        .p1_addr_a(p1_addr_a), .p1_addr_b(p1_addr_b), .p1_addr_d(p1_addr_d),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid),
        .p1_rdata_a(p1_rdata_a), .p1_rdata_b(p1_rdata_b),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b), .ram_addr_d(ram_addr_d),
        .ram_data_in(ram_data_in), .ram_we(ram_we),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
        .conflict_cnt(conflict_cnt)
    );

    // Register-file RAM: registered reads, reads suppressed in write cycles.
    logic [DW-1:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr_d] <= ram_data_in;
        end else begin
            ram_q_a <= ram_mem[ram_addr_a];
            ram_q_b <= ram_mem[ram_addr_b];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] exp_mem [0:255];
    int            m_last = 1;
    int            pend   = -1;
    logic [DW-1:0] pend_a, pend_b;
    int            m_cnt  = 0;
    int            cur_w  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic v, input logic wr,
                       input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic [DW-1:0] wd);
        if (p == 0) begin
            p0_valid = v; p0_wr = wr; p0_addr_a = a; p0_addr_b = b; p0_addr_d = d; p0_wdata = wd;
        end else begin
            p1_valid = v; p1_wr = wr; p1_addr_a = a; p1_addr_b = b; p1_addr_d = d; p1_wdata = wd;
        end
    endtask

    // One clock: compare all outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        int            w;
        logic [AW-1:0] ea, eb, ed;
        logic [DW-1:0] ew;
        logic          ewe;
        @(negedge clk);
        w = -1;
        if (!rst) begin
            if (p0_valid && p1_valid) w = (m_last == 0) ? 1 : 0;
            else if (p0_valid)        w = 0;
            else if (p1_valid)        w = 1;
        end
        ea = '0; eb = '0; ed = '0; ew = '0; ewe = 1'b0;
        if (w == 0) begin
            ea = p0_addr_a; eb = p0_addr_b; ed = p0_addr_d; ew = p0_wdata; ewe = p0_wr;
        end else if (w == 1) begin
            ea = p1_addr_a; eb = p1_addr_b; ed = p1_addr_d; ew = p1_wdata; ewe = p1_wr;
        end
        chk("p0_ready", 32'(p0_ready), 32'(w == 0));
        chk("p1_ready", 32'(p1_ready), 32'(w == 1));
        chk("ram_we", 32'(ram_we), 32'(ewe));
        chk("ram_addr_a", 32'(ram_addr_a), 32'(ea));
        chk("ram_addr_b", 32'(ram_addr_b), 32'(eb));
        chk("ram_addr_d", 32'(ram_addr_d), 32'(ed));
        chk("ram_data_in", ram_data_in, ew);
        chk("p0_rvalid", 32'(p0_rvalid), 32'(!rst && pend == 0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(!rst && pend == 1));
        if (!rst && pend == 0) begin
            chk("p0_rdata_a", p0_rdata_a, pend_a);
            chk("p0_rdata_b", p0_rdata_b, pend_b);
        end
        if (!rst && pend == 1) begin
            chk("p1_rdata_a", p1_rdata_a, pend_a);
            chk("p1_rdata_b", p1_rdata_b, pend_b);
        end
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        cur_w = w;
        if (rst) begin
            m_last = 1; pend = -1; m_cnt = 0;
        end else begin
            pend = -1;
            if (w >= 0) begin
                m_last = w;
                if (ewe) begin
                    exp_mem[ed] = ew;
                end else begin
                    pend = w; pend_a = exp_mem[ea]; pend_b = exp_mem[eb];
                end
            end
            if (p0_valid && p1_valid && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Preload the low 32 words so every read in the run has a known value.
        for (int i = 0; i < 32; i++) begin
            drv(1, 1, 1, 0, 0, AW'(i), $urandom);
            cycle();
        end
        drv(1, 0, 0, 0, 0, 0, 0);

        // Write then read back on port 0.
        drv(0, 1, 1, 0, 0, 8'h05, 32'hDEADBEEF);
        cycle();
        drv(0, 1, 0, 8'h05, 8'h00, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("t1_rvalid", 32'(p0_rvalid), 32'd1);
        chk("t1_rdata_a", p0_rdata_a, 32'hDEADBEEF);
        chk("t1_p1_rvalid", 32'(p1_rvalid), 32'd0);
        cycle();

        // Continuous contention from reset: strict alternation.
        do_reset();
        drv(0, 1, 0, 8'h01, 8'h02, 0, 0);
        drv(1, 1, 0, 8'h03, 8'h04, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_rv_p0", 32'(p0_rvalid), 32'(i % 2 == 0));
            chk("t2_rv_p1", 32'(p1_rvalid), 32'(i % 2 == 1));
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t2_cnt", 32'(conflict_cnt), 32'd4);
        cycle();

        // Write and read to the same address contending: write goes first.
        do_reset();
        drv(0, 1, 1, 0, 0, 8'h10, 32'h1);
        drv(1, 1, 0, 8'h10, 8'h00, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        cycle();
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t3_rvalid", 32'(p1_rvalid), 32'd1);
        chk("t3_rdata_a", p1_rdata_a, 32'h1);
        cycle();

        // Port 1 alone, three back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, AW'(i + 8), AW'(i + 20), 0, 0);
            #1;
            chk("t4_ready", 32'(p1_ready), 32'd1);
            cycle();
            chk("t4_rvalid", 32'(p1_rvalid), 32'd1);
        end
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t4_cnt", 32'(conflict_cnt), 32'd1);
        cycle();

        // Saturation of the contention counter.
        do_reset();
        drv(0, 1, 0, 8'h06, 8'h07, 0, 0);
        drv(1, 1, 0, 8'h08, 8'h09, 0, 0);
        repeat ((1 << CW) + 5) cycle();
        chk("t5_sat", 32'(conflict_cnt), 32'hF);
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("t5_hold", 32'(conflict_cnt), 32'hF);

        // Read in flight when reset arrives is dropped; arbitration restarts at port 0.
        drv(0, 1, 0, 8'h0A, 8'h0B, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("t6_rvalid", 32'(p0_rvalid), 32'd0);
        cycle();
        rst = 1'b0;
        drv(0, 1, 0, 8'h0C, 8'h0D, 0, 0);
        drv(1, 1, 0, 8'h0E, 8'h0F, 0, 0);
        #1;
        chk("t6_p0_first", 32'(p0_ready), 32'd1);
        chk("t6_p1_wait", 32'(p1_ready), 32'd0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic; a waiting port keeps its command stable.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!(p0_valid && cur_w != 0)) begin
                drv(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                    AW'($urandom_range(0, 31)), $urandom);
            end
            if (!(p1_valid && cur_w != 1)) begin
                drv(1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                    AW'($urandom_range(0, 31)), $urandom);
            end
            cycle();
        end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
